// File: rtl/mandel_view_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mandel_view_ctrl
// Purpose  : View controller ahead of the Mandelbrot render engine. Holds the
//            view centre (cx, cy) and per-pixel step in signed fixed point.
//            Turns zoom/pan button edges into x_start/y_start/step plus a
//            one-cycle start pulse. At most one merged request is held while
//            a render is in flight.
// Ports    : clk, rst_n (async, active low)
//            zoom_in, zoom_out, pan_left, pan_right, pan_up, pan_down
//              - level request inputs, acted on at their rising edge
//            render_busy - engine activity (monitor only)
//            render_done - engine completion pulse
//            start       - one-cycle render start pulse
//            x_start, y_start, step - view handed to the engine
//            busy        - high from start until render_done
// Options  : MANDEL_AUTOZOOM_EN - when defined, an idle controller with no
//            pending request keeps zooming in until step reaches STEP_MIN.
// Revision : 1.0 - initial release
// ============================================================================
module mandel_view_ctrl #(
  parameter int FB_WIDTH  = 320,
  parameter int FB_HEIGHT = 180,
  parameter int FP_WIDTH  = 25,
  parameter int FP_INT    = 4,
  parameter int STEP_INIT = 'h5000,
  parameter int STEP_MIN  = 1,
  parameter int STEP_MAX  = 'h40000,
  parameter int CX_INIT   = -1572864,
  parameter int CY_INIT   = 0,
  parameter int PAN_PIX   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       zoom_in,
  input  logic                       zoom_out,
  input  logic                       pan_left,
  input  logic                       pan_right,
  input  logic                       pan_up,
  input  logic                       pan_down,
  input  logic                       render_busy,
  input  logic                       render_done,
  output logic                       start,
  output logic signed [FP_WIDTH-1:0] x_start,
  output logic signed [FP_WIDTH-1:0] y_start,
  output logic signed [FP_WIDTH-1:0] step,
  output logic                       busy
);

  // Products and sums are formed at double width, then clamped.
  localparam int PW   = 2 * FP_WIDTH;
  localparam int NREQ = 6;

  // Request bit positions
  localparam int REQ_ZI = 0;
  localparam int REQ_ZO = 1;
  localparam int REQ_L  = 2;
  localparam int REQ_R  = 3;
  localparam int REQ_U  = 4;
  localparam int REQ_D  = 5;

  localparam logic [2:0] S_BOOT   = 3'd0;
  localparam logic [2:0] S_IDLE   = 3'd1;
  localparam logic [2:0] S_CALC   = 3'd2;
  localparam logic [2:0] S_LAUNCH = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;

  localparam logic signed [FP_WIDTH-1:0] C_STEP_INIT = FP_WIDTH'(STEP_INIT);
  localparam logic signed [FP_WIDTH-1:0] C_STEP_MIN  = FP_WIDTH'(STEP_MIN);
  localparam logic signed [FP_WIDTH-1:0] C_STEP_MAX  = FP_WIDTH'(STEP_MAX);
  localparam logic signed [FP_WIDTH-1:0] C_CX_INIT   = FP_WIDTH'(CX_INIT);
  localparam logic signed [FP_WIDTH-1:0] C_CY_INIT   = FP_WIDTH'(CY_INIT);

  localparam logic signed [PW-1:0] C_SAT_HI   = PW'((64'sd1 <<< (FP_WIDTH - 1)) - 64'sd1);
  localparam logic signed [PW-1:0] C_SAT_LO   = PW'(-(64'sd1 <<< (FP_WIDTH - 1)));
  localparam logic signed [PW-1:0] C_HALF_W   = PW'(FB_WIDTH / 2);
  localparam logic signed [PW-1:0] C_HALF_H   = PW'(FB_HEIGHT / 2);
  localparam logic signed [PW-1:0] C_PAN      = PW'(PAN_PIX);
  localparam logic signed [PW-1:0] C_STEP_MXW = PW'(STEP_MAX);

  // Clamp a double-width value into the signed FP_WIDTH range.
  function automatic logic signed [FP_WIDTH-1:0] f_sat(input logic signed [PW-1:0] v);
    if (v > C_SAT_HI) begin
      f_sat = C_SAT_HI[FP_WIDTH-1:0];
    end else if (v < C_SAT_LO) begin
      f_sat = C_SAT_LO[FP_WIDTH-1:0];
    end else begin
      f_sat = v[FP_WIDTH-1:0];
    end
  endfunction

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic [2:0]                 r_state;
  logic [2:0]                 w_state_nxt;

  logic [NREQ-1:0]            w_req_raw;
  logic [NREQ-1:0]            r_req_sync;
  logic [NREQ-1:0]            r_req_hist;
  logic [NREQ-1:0]            w_fire;
  logic [NREQ-1:0]            r_pending;
  logic [NREQ-1:0]            w_req_user;
  logic [NREQ-1:0]            w_req;

  logic signed [FP_WIDTH-1:0] r_cx;
  logic signed [FP_WIDTH-1:0] r_cy;
  logic signed [FP_WIDTH-1:0] r_step_view;

  logic signed [FP_WIDTH-1:0] w_step_half;
  logic signed [PW-1:0]       w_step_dbl;
  logic signed [FP_WIDTH-1:0] w_step_new;
  logic signed [PW-1:0]       w_pan;
  logic signed [FP_WIDTH-1:0] w_cx_new;
  logic signed [FP_WIDTH-1:0] w_cy_new;
  logic                       w_view_changed;
  logic                       w_go;

  logic signed [PW-1:0]       w_xoff;
  logic signed [PW-1:0]       w_yoff;
  logic signed [FP_WIDTH-1:0] w_x_calc;
  logic signed [FP_WIDTH-1:0] w_y_calc;

  logic                       w_load_view;
  logic                       w_calc;
  logic                       w_start_nxt;
  logic                       w_busy_nxt;

  // render_busy is informational only; FP_INT only documents the format.
  logic                       w_unused;
  assign w_unused = &{1'b0, render_busy, (FP_INT >= 0)};

  // --------------------------------------------------------------------------
  // Request edge detection and pending capture
  // --------------------------------------------------------------------------
  assign w_req_raw = {pan_down, pan_up, pan_right, pan_left, zoom_out, zoom_in};

  // History resets to all ones so buttons held through reset never fire.
  assign w_fire = r_req_sync & ~r_req_hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_sync <= '1;
      r_req_hist <= '1;
      r_pending  <= '0;
    end else begin
      r_req_sync <= w_req_raw;
      r_req_hist <= r_req_sync;
      // IDLE either applies or discards everything it sees, so pending
      // only accumulates while a render is being prepared or in flight.
      if (r_state == S_IDLE) begin
        r_pending <= '0;
      end else begin
        r_pending <= r_pending | w_fire;
      end
    end
  end

  // A fresh edge arriving in IDLE joins whatever is already pending.
  assign w_req_user = r_pending | w_fire;

`ifdef MANDEL_AUTOZOOM_EN
  // Nothing requested: behave as an implicit zoom_in. Once the step is
  // pinned at STEP_MIN the view stops changing and no render is launched.
  assign w_req = (w_req_user == '0) ? NREQ'(1 << REQ_ZI) : w_req_user;
`else
  assign w_req = w_req_user;
`endif

  // --------------------------------------------------------------------------
  // View update (zoom first, then pan with the new step)
  // --------------------------------------------------------------------------
  assign w_step_half = r_step_view >>> 1;
  assign w_step_dbl  = PW'(r_step_view) <<< 1;

  always_comb begin
    w_step_new = r_step_view;
    if (w_req[REQ_ZI] && !w_req[REQ_ZO]) begin
      w_step_new = (w_step_half < C_STEP_MIN) ? C_STEP_MIN : w_step_half;
    end else if (w_req[REQ_ZO] && !w_req[REQ_ZI]) begin
      w_step_new = (w_step_dbl > C_STEP_MXW) ? C_STEP_MAX : w_step_dbl[FP_WIDTH-1:0];
    end
  end

  assign w_pan = PW'(w_step_new) * C_PAN;

  always_comb begin
    w_cx_new = r_cx;
    w_cy_new = r_cy;
    if (w_req[REQ_R] && !w_req[REQ_L]) begin
      w_cx_new = f_sat(PW'(r_cx) + w_pan);
    end else if (w_req[REQ_L] && !w_req[REQ_R]) begin
      w_cx_new = f_sat(PW'(r_cx) - w_pan);
    end
    if (w_req[REQ_D] && !w_req[REQ_U]) begin
      w_cy_new = f_sat(PW'(r_cy) + w_pan);
    end else if (w_req[REQ_U] && !w_req[REQ_D]) begin
      w_cy_new = f_sat(PW'(r_cy) - w_pan);
    end
  end

  // Saturated or cancelled requests leave the view untouched: no render.
  assign w_view_changed = (w_step_new != r_step_view) ||
                          (w_cx_new != r_cx) || (w_cy_new != r_cy);
  assign w_go = (w_req != '0) && w_view_changed;

  // --------------------------------------------------------------------------
  // Corner computation
  // --------------------------------------------------------------------------
  assign w_xoff   = PW'(r_step_view) * C_HALF_W;
  assign w_yoff   = PW'(r_step_view) * C_HALF_H;
  assign w_x_calc = f_sat(PW'(r_cx) - w_xoff);
  assign w_y_calc = f_sat(PW'(r_cy) - w_yoff);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_BOOT:   w_state_nxt = S_CALC;
      S_IDLE:   w_state_nxt = w_go ? S_CALC : S_IDLE;
      S_CALC:   w_state_nxt = S_LAUNCH;
      S_LAUNCH: w_state_nxt = S_WAIT;
      S_WAIT:   w_state_nxt = render_done ? S_IDLE : S_WAIT;
      default:  w_state_nxt = S_BOOT;
    endcase
  end

  // FSM: output logic
  always_comb begin
    w_load_view = (r_state == S_IDLE) && w_go;
    w_calc      = (r_state == S_CALC);
    w_start_nxt = (r_state == S_LAUNCH);
    w_busy_nxt  = busy;
    if (r_state == S_LAUNCH) begin
      w_busy_nxt = 1'b1;
    end else if ((r_state == S_WAIT) && render_done) begin
      w_busy_nxt = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // View and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cx        <= C_CX_INIT;
      r_cy        <= C_CY_INIT;
      r_step_view <= C_STEP_INIT;
    end else if (w_load_view) begin
      r_cx        <= w_cx_new;
      r_cy        <= w_cy_new;
      r_step_view <= w_step_new;
    end
  end

  // Engine-facing view only changes in CALC, so it is stable from LAUNCH
  // through the whole render and until the next view is computed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_start <= '0;
      y_start <= '0;
      step    <= C_STEP_INIT;
    end else if (w_calc) begin
      x_start <= w_x_calc;
      y_start <= w_y_calc;
      step    <= r_step_view;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start <= 1'b0;
      busy  <= 1'b0;
    end else begin
      start <= w_start_nxt;
      busy  <= w_busy_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mandel_view_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mandel_view_ctrl
// Purpose  : Self-checking bench for mandel_view_ctrl (default build). A
//            behavioural view model predicts each render; predictions go to a
//            scoreboard queue that a monitor drains on every start pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mandel_view_ctrl;

  localparam longint FP_HI     = (64'sd1 <<< 24) - 1;
  localparam longint FP_LO     = -(64'sd1 <<< 24);
  localparam longint STEP_INIT = 20480;
  localparam longint STEP_MIN  = 1;
  localparam longint STEP_MAX  = 262144;
  localparam longint CX_INIT   = -1572864;
  localparam longint CY_INIT   = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic zoom_in = 1'b0, zoom_out = 1'b0;
  logic pan_left = 1'b0, pan_right = 1'b0, pan_up = 1'b0, pan_down = 1'b0;
  logic render_busy = 1'b0, render_done = 1'b0;
  logic start, busy;
  logic signed [24:0] x_start, y_start, step;

  mandel_view_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .zoom_in     (zoom_in),
    .zoom_out    (zoom_out),
    .pan_left    (pan_left),
    .pan_right   (pan_right),
    .pan_up      (pan_up),
    .pan_down    (pan_down),
    .render_busy (render_busy),
    .render_done (render_done),
    .start       (start),
    .x_start     (x_start),
    .y_start     (y_start),
    .step        (step),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint x;
    longint y;
    longint s;
    int     cyc;   // expected monitor cycle of the start pulse, -1 = any
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int n_starts = 0;

  // Reference view
  longint m_cx, m_cy, m_step;

  function automatic longint clamp(longint v);
    if (v > FP_HI) return FP_HI;
    if (v < FP_LO) return FP_LO;
    return v;
  endfunction

  function automatic void m_reset();
    m_cx = CX_INIT;
    m_cy = CY_INIT;
    m_step = STEP_INIT;
  endfunction

  // bits: 0 zoom_in, 1 zoom_out, 2 left, 3 right, 4 up, 5 down
  function automatic bit m_apply(logic [5:0] b);
    longint ns, ncx, ncy, d;
    bit ch;
    ns = m_step;
    if (b[0] && !b[1]) ns = (m_step / 2 < STEP_MIN) ? STEP_MIN : m_step / 2;
    else if (b[1] && !b[0]) ns = (m_step * 2 > STEP_MAX) ? STEP_MAX : m_step * 2;
    d = ns * 16;
    ncx = m_cx;
    ncy = m_cy;
    if (b[3] && !b[2]) ncx = clamp(m_cx + d);
    else if (b[2] && !b[3]) ncx = clamp(m_cx - d);
    if (b[5] && !b[4]) ncy = clamp(m_cy + d);
    else if (b[4] && !b[5]) ncy = clamp(m_cy - d);
    ch = (ns != m_step) || (ncx != m_cx) || (ncy != m_cy);
    m_step = ns;
    m_cx = ncx;
    m_cy = ncy;
    return ch;
  endfunction

  function automatic void push_exp(int c);
    exp_t e;
    e.x = clamp(m_cx - m_step * 160);
    e.y = clamp(m_cy - m_step * 90);
    e.s = m_step;
    e.cyc = c;
    sb.push_back(e);
  endfunction

  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // --------------------------------------------------------------------------
  // Monitor: scoreboard on start pulses, busy tracking every cycle
  // --------------------------------------------------------------------------
  initial begin : monitor
    logic exp_busy;
    exp_t e;
    exp_busy = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        exp_busy = 1'b0;
      end else begin
        if (start) begin
          n_starts++;
          exp_busy = 1'b1;
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_start: got start=1, expected no start (cycle %0d)", cyc);
          end else begin
            e = sb.pop_front();
            check("x_start", x_start, e.x);
            check("y_start", y_start, e.y);
            check("step", step, e.s);
            if (e.cyc >= 0) check("start_cycle", cyc, e.cyc);
          end
        end
        check("busy", busy, exp_busy);
        if (render_done) exp_busy = 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  logic [5:0] plan[$];
  bit rand_wait = 1'b0;

  task automatic set_btn(logic [5:0] b);
    zoom_in   = b[0];
    zoom_out  = b[1];
    pan_left  = b[2];
    pan_right = b[3];
    pan_up    = b[4];
    pan_down  = b[5];
  endtask

  function automatic logic [5:0] rand_bits();
    logic [5:0] b;
    for (int i = 0; i < 6; i++) b[i] = ($urandom_range(0, 3) == 0);
    return b;
  endfunction

  task automatic press_only(logic [5:0] b);
    @(negedge clk);
    set_btn(b);
    repeat (2) @(negedge clk);
    set_btn('0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_start();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #2;
      if (start) return;
    end
    checks++;
    errors++;
    $display("FAIL start_timeout: got no start in 40 cycles, expected a start pulse (cycle %0d)", cyc);
    sb.delete();
  endtask

  task automatic check_no_start();
    int n0;
    n0 = n_starts;
    repeat (8) @(negedge clk);
    check("no_start", n_starts, n0);
  endtask

  // Called right after a start is seen: plays the engine, optionally issues
  // requests during the render, and follows any merged re-render.
  task automatic serve_render();
    logic [5:0] pend, b;
    int k;
    forever begin
      render_busy = 1'b1;
      pend = '0;
      if (plan.size() > 0) begin
        while (plan.size() > 0) begin
          b = plan.pop_front();
          pend |= b;
          press_only(b);
        end
      end else if (rand_wait) begin
        k = $urandom_range(0, 3);
        for (int i = 0; i < k; i++) begin
          b = rand_bits();
          pend |= b;
          press_only(b);
        end
      end
      repeat ($urandom_range(1, 6)) @(negedge clk);
      render_done = 1'b1;
      render_busy = 1'b0;
      @(negedge clk);
      render_done = 1'b0;
      if (m_apply(pend)) begin
        push_exp(-1);
        wait_start();
      end else begin
        check_no_start();
        break;
      end
    end
  endtask

  // Request from IDLE; returns with the start already seen when one is due.
  task automatic idle_req(logic [5:0] b, output bit ch);
    int c;
    ch = m_apply(b);
    @(negedge clk);
    set_btn(b);
    c = cyc;
    if (ch) push_exp(c + 4);
    repeat (2) @(negedge clk);
    set_btn('0);
    if (ch) wait_start();
    else check_no_start();
  endtask

  task automatic do_req(logic [5:0] b);
    bit ch;
    idle_req(b, ch);
    if (ch) serve_render();
  endtask

  task automatic release_reset();
    int c;
    @(negedge clk);
    rst_n = 1'b1;
    c = cyc;
    m_reset();
    push_exp(c + 3);
    wait_start();
  endtask

  task automatic check_reset_outputs();
    check("rst_start", start, 0);
    check("rst_busy", busy, 0);
    check("rst_x_start", x_start, 0);
    check("rst_y_start", y_start, 0);
    check("rst_step", step, STEP_INIT);
  endtask

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin : stim
    bit ch;
    m_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs();

    // Boot render
    release_reset();
    check("boot_x", x_start, -4849664);
    check("boot_y", y_start, -1843200);
    check("boot_step", step, 20480);
    serve_render();

    // Pan right at step 20480, then back
    idle_req(6'b001000, ch);
    check("pan_r_x", x_start, -4521984);
    check("pan_r_y", y_start, -1843200);
    serve_render();
    do_req(6'b000100);

    // Zoom in from IDLE
    idle_req(6'b000001, ch);
    check("zi_step", step, 10240);
    check("zi_x", x_start, -3211264);
    check("zi_y", y_start, -921600);
    serve_render();

    // Back to 20480; during that render: zoom_in x2 + pan_up -> one re-render
    plan.push_back(6'b000001);
    plan.push_back(6'b000001);
    plan.push_back(6'b010000);
    idle_req(6'b000010, ch);
    check("zo_step", step, 20480);
    serve_render();
    check("merge_step", step, 10240);
    check("merge_y", y_start, -163840 - 921600);

    // Saturate at STEP_MAX, then zoom_out and zoom_in+zoom_out do nothing
    repeat (6) do_req(6'b000010);
    check("max_step", step, STEP_MAX);
    do_req(6'b000010);
    check("max_hold", step, STEP_MAX);
    do_req(6'b000011);
    check("cancel_hold", step, STEP_MAX);
    repeat (3) do_req(6'b000001);

    // Reset while waiting with a pending request
    idle_req(6'b000001, ch);
    render_busy = 1'b1;
    press_only(6'b000001);
    @(negedge clk);
    rst_n = 1'b0;
    render_busy = 1'b0;
    #1;
    check_reset_outputs();
    check("rst_sb_empty", sb.size(), 0);
    m_reset();
    repeat (3) @(negedge clk);
    release_reset();
    check("reboot_x", x_start, -4849664);
    check("reboot_step", step, 20480);
    serve_render();

    // Randomized requests, including requests during renders
    rand_wait = 1'b1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      do_req(rand_bits());
    end

    repeat (10) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got no end of test, expected finish before %0d cycles", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
